logic_level_receiver: RTL and testbench
=======================================

Name: logic_level_receiver

Overview:
- Clocked receiver for logic levels on a quantized analog node: digital sampled input in, clean logic state out.
- Counterpart of the threshold/hysteresis logic-gate drivers used in mixed-signal models.
- Classifies each sample against high/low thresholds with hysteresis and rejects glitches shorter than DELAY samples.
- Flags an unknown state when the node dwells between thresholds; emits edge strobes and reports the length of the previous level.

Parameters:
- W, 8, width of the sampled node code (0 = vmin, 2^W-1 = vmax).
- THH, 230, high threshold code (about 0.9 of vmax); a sample >= THH is class HI.
- THL, 25, low threshold code (about 0.1 of vmax); a sample <= THL is class LO. THL < THH is required; elaboration fails otherwise.
- DELAY, 4, consecutive qualifying valid samples needed to change level (>= 1).
- XTIMEOUT, 16, consecutive MID valid samples that force UNK (>= 1).
- CW, 16, width of the level-length counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- vin  in  W  sampled node code
- vin_valid  in  1  vin is a new sample this cycle
- dout  out  1  current logic level (0 while UNK)
- dx  out  1  level is UNK
- rise  out  1  one-cycle strobe on a LOW->HIGH change
- fall  out  1  one-cycle strobe on a HIGH->LOW change
- last_len  out  CW  valid-sample count spent in the level just left
- len_strobe  out  1  one-cycle strobe when last_len updates

Behaviour:
- Sample class (combinational on vin):
  - HI if vin >= THH.
  - LO if vin <= THL.
  - MID otherwise.
- Level states: UNK, LOW, HIGH. Outputs are registered: dout = (state==HIGH), dx = (state==UNK).
- Reset (async, takes effect immediately):
  - state = UNK, so dx = 1 and dout = 0.
  - rise, fall and len_strobe = 0; last_len = 0.
  - All internal counters = 0.
  - A reset mid-transition discards partial counts.
- vin_valid = 0: no counter changes, no state change; strobes are 0.
- Transition counter tcnt (per valid sample):
  - Target class: HI when state is LOW, LO when state is HIGH, HI or LO when state is UNK.
  - In UNK the target is the class of the first qualifying sample; a sample of the other class restarts the count with the new class as target.
  - A valid target-class sample increments tcnt. Any other valid sample (including MID) clears tcnt.
  - When tcnt == DELAY-1 and a valid target sample arrives, state changes at that clock edge and tcnt clears.
  - Latency: with DELAY=4, the 4th consecutive qualifying sample's edge updates dout. With DELAY=1, dout updates on the first qualifying sample's edge.
- MID counter mcnt:
  - In LOW/HIGH, a valid MID sample increments mcnt; a valid HI or LO sample clears it.
  - When mcnt == XTIMEOUT-1 and another MID arrives, state becomes UNK and mcnt clears.
  - In UNK, mcnt is held at 0.
  - Hysteresis: MID samples never change LOW/HIGH before the timeout.
- Simultaneous events: when tcnt and mcnt would both fire on one sample, the transition wins. This is impossible by class, but the implementation must encode the priority.
- Edge strobes:
  - rise pulses in the cycle after a LOW->HIGH change; fall pulses in the cycle after a HIGH->LOW change (registered alongside state).
  - UNK<->LOW/HIGH changes produce no rise or fall.
- Length counter lcnt:
  - Counts valid samples while in the current state, saturating at 2^CW-1.
  - On any state change, last_len <= lcnt + 1 (saturated), len_strobe pulses, and lcnt clears.
  - The sample that triggers the change is counted in the old level.
- Samples equal to THH or THL qualify; no other special boundary at vmax or vmin.

Test Plan:
- Reset, then vin=255 valid for 4 cycles -> dx=1, dout=0 for cycles 1-3; after the 4th edge dout=1, dx=0, no rise pulse, len_strobe=1, last_len=4.
- In HIGH, glitch vin=0 for 3 valid cycles then 255 -> dout stays 1, no fall; then vin=0 for 4 cycles -> dout=0 after the 4th edge, fall=1 for one cycle.
- In LOW, vin=128 (MID) for 15 valid cycles then 0 -> stays LOW, dx=0; then 16 MID cycles -> dx=1 after the 16th edge, no edge strobe.
- Slow ramp LOW: 10,60,120,200,230,240,250,255 valid -> tcnt starts at 230; dout=1 after the 255 sample (4th HI), rise=1, last_len = valid count spent in LOW.
- In HIGH with tcnt=2 (two LO samples), insert vin_valid=0 cycles, then 2 more LO samples -> fall asserted; invalid cycles neither reset nor advance the counters.
- Assert rst during a HIGH->LOW transition with tcnt=3 -> immediately dx=1, dout=0, last_len=0; next 3 LO samples leave dx=1, the 4th sets LOW with no fall.

Source files
------------

// File: rtl/logic_level_receiver.sv
// logic_level_receiver: turns a quantized analog node code into a clean logic
// level using high/low thresholds with hysteresis, glitch rejection over DELAY
// valid samples, an unknown state when the node dwells between thresholds,
// edge strobes, and the length of the level just left.
module logic_level_receiver #(
    parameter int W        = 8,
    parameter int THH      = 230,
    parameter int THL      = 25,
    parameter int DELAY    = 4,
    parameter int XTIMEOUT = 16,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  vin,
    input  logic          vin_valid,
    output logic          dout,
    output logic          dx,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] last_len,
    output logic          len_strobe
);

    // Counter widths only need to hold DELAY-1 and XTIMEOUT-1.
    localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int MW = (XTIMEOUT > 1) ? $clog2(XTIMEOUT) : 1;

    localparam logic [W-1:0]  THH_C  = W'(THH);
    localparam logic [W-1:0]  THL_C  = W'(THL);
    localparam logic [TW-1:0] T_LAST = TW'(DELAY - 1);
    localparam logic [MW-1:0] M_LAST = MW'(XTIMEOUT - 1);

    // Reject parameter sets that make the hysteresis band meaningless.
    if (THL >= THH) begin : g_bad_thresholds
        $error("logic_level_receiver: THL must be below THH");
    end
    if (DELAY < 1 || XTIMEOUT < 1) begin : g_bad_counts
        $error("logic_level_receiver: DELAY and XTIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_UNK,
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          utgt_hi_q, utgt_hi_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [CW-1:0] last_len_q, last_len_d;
    logic          dout_q, dout_d;
    logic          dx_q, dx_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          len_strobe_q, len_strobe_d;

    logic is_hi, is_lo, is_mid;

    // Classify the current sample against the two thresholds.
    always_comb begin
        is_hi  = (vin >= THH_C);
        is_lo  = (vin <= THL_C);
        is_mid = !is_hi && !is_lo;
    end

    // Next-state logic: transition and dwell counters, level length, strobes.
    always_comb begin
        logic          hit;
        logic          fire_t;
        logic          fire_m;
        logic [TW-1:0] base;
        logic [CW-1:0] lcnt_inc;
        state_t        dest;

        state_d      = state_q;
        tcnt_d       = tcnt_q;
        utgt_hi_d    = utgt_hi_q;
        mcnt_d       = mcnt_q;
        lcnt_d       = lcnt_q;
        last_len_d   = last_len_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        len_strobe_d = 1'b0;
        hit          = 1'b0;
        fire_t       = 1'b0;
        fire_m       = 1'b0;
        base         = tcnt_q;
        dest         = state_q;
        lcnt_inc     = (&lcnt_q) ? lcnt_q : lcnt_q + 1'b1;

        if (vin_valid) begin
            unique case (state_q)
                ST_LOW: begin
                    hit  = is_hi;
                    dest = ST_HIGH;
                end
                ST_HIGH: begin
                    hit  = is_lo;
                    dest = ST_LOW;
                end
                default: begin
                    // A qualifying sample of the other class restarts the run.
                    hit  = is_hi || is_lo;
                    base = (utgt_hi_q == is_hi) ? tcnt_q : '0;
                    dest = is_hi ? ST_HIGH : ST_LOW;
                    if (hit) begin
                        utgt_hi_d = is_hi;
                    end
                end
            endcase

            if (hit) begin
                if (base == T_LAST) begin
                    fire_t = 1'b1;
                    tcnt_d = '0;
                end else begin
                    tcnt_d = base + 1'b1;
                end
            end else begin
                tcnt_d = '0;
            end

            if (state_q == ST_UNK || !is_mid) begin
                mcnt_d = '0;
            end else if (mcnt_q == M_LAST) begin
                fire_m = 1'b1;
                mcnt_d = '0;
            end else begin
                mcnt_d = mcnt_q + 1'b1;
            end

            // A completed transition takes priority over the dwell timeout.
            if (fire_t) begin
                state_d = dest;
                mcnt_d  = '0;
            end else if (fire_m) begin
                state_d = ST_UNK;
                tcnt_d  = '0;
            end

            if (state_d != state_q) begin
                last_len_d   = lcnt_inc;
                len_strobe_d = 1'b1;
                lcnt_d       = '0;
                rise_d       = (state_q == ST_LOW) && (state_d == ST_HIGH);
                fall_d       = (state_q == ST_HIGH) && (state_d == ST_LOW);
            end else begin
                lcnt_d = lcnt_inc;
            end
        end

        dout_d = (state_d == ST_HIGH);
        dx_d   = (state_d == ST_UNK);
    end

    // State and registered outputs; reset discards any partial counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_UNK;
            tcnt_q       <= '0;
            utgt_hi_q    <= 1'b0;
            mcnt_q       <= '0;
            lcnt_q       <= '0;
            last_len_q   <= '0;
            dout_q       <= 1'b0;
            dx_q         <= 1'b1;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            len_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tcnt_q       <= tcnt_d;
            utgt_hi_q    <= utgt_hi_d;
            mcnt_q       <= mcnt_d;
            lcnt_q       <= lcnt_d;
            last_len_q   <= last_len_d;
            dout_q       <= dout_d;
            dx_q         <= dx_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            len_strobe_q <= len_strobe_d;
        end
    end

    assign dout       = dout_q;
    assign dx         = dx_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign last_len   = last_len_q;
    assign len_strobe = len_strobe_q;

endmodule

// File: tb/tb_logic_level_receiver.sv
// Bench for logic_level_receiver: directed scenarios with literal expectations
// plus randomized runs, all checked every cycle against a history-based model.
module tb_logic_level_receiver;

    localparam int W        = 8;
    localparam int THH      = 230;
    localparam int THL      = 25;
    localparam int DELAY    = 4;
    localparam int XTIMEOUT = 16;
    localparam int CW       = 16;
    localparam int LMAX     = (1 << CW) - 1;

    localparam int C_LO  = 0;
    localparam int C_MID = 1;
    localparam int C_HI  = 2;
    localparam int S_UNK  = 0;
    localparam int S_LOW  = 1;
    localparam int S_HIGH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  vin = '0;
    logic          vin_valid = 1'b0;
    logic          dout, dx, rise, fall, len_strobe;
    logic [CW-1:0] last_len;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // Reference model: level plus the classes seen since the last level change.
    int m_state;
    int hist[$];
    int m_len;
    int exp_last_len;
    bit exp_rise, exp_fall, exp_ls;

    logic_level_receiver #(
        .W(W), .THH(THH), .THL(THL), .DELAY(DELAY), .XTIMEOUT(XTIMEOUT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .vin(vin), .vin_valid(vin_valid),
        .dout(dout), .dx(dx), .rise(rise), .fall(fall),
        .last_len(last_len), .len_strobe(len_strobe)
    );

    always #5 clk = ~clk;

    function automatic int classify(input int v);
        if (v >= THH) return C_HI;
        if (v <= THL) return C_LO;
        return C_MID;
    endfunction

    // True when the newest n entries of the history all equal class c.
    function automatic bit tail_all(input int n, input int c);
        if (hist.size() < n) return 1'b0;
        for (int k = hist.size() - n; k < hist.size(); k++)
            if (hist[k] != c) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = S_UNK;
        hist.delete();
        m_len = 0;
        exp_last_len = 0;
        exp_rise = 1'b0;
        exp_fall = 1'b0;
        exp_ls = 1'b0;
    endtask

    task automatic model_step(input int v, input bit valid);
        int c, tgt, nxt;
        exp_rise = 1'b0;
        exp_fall = 1'b0;
        exp_ls = 1'b0;
        if (!valid) return;
        c = classify(v);
        hist.push_back(c);
        if (hist.size() > 64) void'(hist.pop_front());
        m_len++;
        if (m_state == S_LOW) tgt = C_HI;
        else if (m_state == S_HIGH) tgt = C_LO;
        else tgt = c;
        nxt = m_state;
        if (tgt != C_MID && c == tgt && tail_all(DELAY, tgt))
            nxt = (tgt == C_HI) ? S_HIGH : S_LOW;
        else if (m_state != S_UNK && tail_all(XTIMEOUT, C_MID))
            nxt = S_UNK;
        if (nxt != m_state) begin
            exp_last_len = (m_len > LMAX) ? LMAX : m_len;
            exp_ls = 1'b1;
            exp_rise = (m_state == S_LOW) && (nxt == S_HIGH);
            exp_fall = (m_state == S_HIGH) && (nxt == S_LOW);
            m_len = 0;
            hist.delete();
            m_state = nxt;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int v, input bit valid);
        vin = W'(v);
        vin_valid = valid;
        @(posedge clk);
        model_step(v, valid);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        model_reset();
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            checkOutput("dout", int'(dout), int'(m_state == S_HIGH));
            checkOutput("dx", int'(dx), int'(m_state == S_UNK));
            checkOutput("rise", int'(rise), int'(exp_rise));
            checkOutput("fall", int'(fall), int'(exp_fall));
            checkOutput("len_strobe", int'(len_strobe), int'(exp_ls));
            checkOutput("last_len", int'(last_len), exp_last_len);
        end
    end

    initial begin
        int lvl;
        int v;
        bit valid;
        int ramp[8];

        model_reset();
        doReset();
        run_cmp = 1'b1;
        checkOutput("rst_dx", int'(dx), 1);
        checkOutput("rst_dout", int'(dout), 0);
        checkOutput("rst_last_len", int'(last_len), 0);

        // UNK -> HIGH after four HI samples, no rise strobe.
        repeat (3) applyStimulus(255, 1'b1);
        checkOutput("t1_dx_pre", int'(dx), 1);
        checkOutput("t1_dout_pre", int'(dout), 0);
        applyStimulus(255, 1'b1);
        checkOutput("t1_dout", int'(dout), 1);
        checkOutput("t1_dx", int'(dx), 0);
        checkOutput("t1_rise", int'(rise), 0);
        checkOutput("t1_len_strobe", int'(len_strobe), 1);
        checkOutput("t1_last_len", int'(last_len), 4);

        // Three-sample glitch is rejected, four-sample run is accepted.
        repeat (3) applyStimulus(0, 1'b1);
        applyStimulus(255, 1'b1);
        checkOutput("t2_glitch_dout", int'(dout), 1);
        checkOutput("t2_glitch_fall", int'(fall), 0);
        repeat (4) applyStimulus(0, 1'b1);
        checkOutput("t2_dout", int'(dout), 0);
        checkOutput("t2_fall", int'(fall), 1);
        checkOutput("t2_last_len", int'(last_len), 8);
        applyStimulus(0, 1'b1);
        checkOutput("t2_fall_once", int'(fall), 0);

        // MID dwell: 15 samples hold LOW, 16 force UNK.
        repeat (15) applyStimulus(128, 1'b1);
        applyStimulus(0, 1'b1);
        checkOutput("t3_hold_dx", int'(dx), 0);
        checkOutput("t3_hold_dout", int'(dout), 0);
        repeat (16) applyStimulus(128, 1'b1);
        checkOutput("t3_unk_dx", int'(dx), 1);
        checkOutput("t3_unk_rise", int'(rise), 0);
        checkOutput("t3_unk_fall", int'(fall), 0);

        // Slow ramp from LOW; only samples >= 230 count towards HIGH.
        repeat (4) applyStimulus(0, 1'b1);
        checkOutput("t4_low", int'(dx), 0);
        ramp = '{10, 60, 120, 200, 230, 240, 250, 255};
        for (int i = 0; i < 7; i++) applyStimulus(ramp[i], 1'b1);
        checkOutput("t4_pre_dout", int'(dout), 0);
        applyStimulus(ramp[7], 1'b1);
        checkOutput("t4_dout", int'(dout), 1);
        checkOutput("t4_rise", int'(rise), 1);
        checkOutput("t4_last_len", int'(last_len), 8);

        // Invalid cycles neither reset nor advance the transition count.
        repeat (2) applyStimulus(0, 1'b1);
        repeat (3) applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b1);
        checkOutput("t5_pre_dout", int'(dout), 1);
        applyStimulus(0, 1'b1);
        checkOutput("t5_fall", int'(fall), 1);

        // Reset during a HIGH->LOW transition discards the partial count.
        repeat (4) applyStimulus(255, 1'b1);
        repeat (3) applyStimulus(0, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput("t6_async_dx", int'(dx), 1);
        checkOutput("t6_async_dout", int'(dout), 0);
        checkOutput("t6_async_last_len", int'(last_len), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) applyStimulus(0, 1'b1);
        checkOutput("t6_still_unk", int'(dx), 1);
        applyStimulus(0, 1'b1);
        checkOutput("t6_low_dx", int'(dx), 0);
        checkOutput("t6_no_fall", int'(fall), 0);

        // Randomized runs of HI/MID/LO with glitches, gaps and rare resets.
        lvl = C_LO;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) lvl = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0)
                v = $urandom_range(0, 255);
            else if (lvl == C_HI)
                v = $urandom_range(THH, 255);
            else if (lvl == C_LO)
                v = $urandom_range(0, THL);
            else
                v = $urandom_range(THL + 1, THH - 1);
            valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 999) == 0) doReset();
            applyStimulus(v, valid);
        end

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
